// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder for the RISC-V-lite MEM stage.
// It accepts a request, waits a programmable latency, commits it, then gives a one-cycle response.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  localparam logic [3:0]  LAT_W   = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;

  logic [31:0] mem [DEPTH];

  logic             commit;
  logic             c_we;
  logic [31:0]      c_addr;
  logic [31:0]      c_wdata;
  logic             c_err;
  logic [IDX_W-1:0] c_idx;

  // With zero latency the commit happens on the accept edge itself, so the
  // live request inputs feed the commit path instead of the latched copies.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = (state_reg != IDLE);
    commit     = 1'b0;
    c_we       = we_reg;
    c_addr     = addr_reg;
    c_wdata    = wdata_reg;
    case (state_reg)
      IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst) begin
          cnt_next = LAT_W;
          if (LAT_W == 4'd0) begin
            state_next = RESP;
            commit     = 1'b1;
            c_we       = req_we;
            c_addr     = req_addr;
            c_wdata    = req_wdata;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_reg <= 4'd1) begin
          cnt_next   = 4'd0;
          commit     = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Full 30-bit word index is compared so high address bits never alias into range.
  assign c_err = (c_addr[1:0] != 2'b00) || (c_addr[31:2] >= DEPTH_W);
  assign c_idx = c_addr[IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg    <= 1'b0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (state_reg == IDLE && req_valid) begin
        we_reg    <= req_we;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
      end
      if (commit) begin
        rsp_err   <= c_err;
        rsp_rdata <= (!c_we && !c_err) ? mem[c_idx] : 32'd0;
      end
    end
  end

  // Storage is deliberately not cleared by reset; reset only blocks a pending write.
  always_ff @(posedge clk) begin
    if (!rst && commit && c_we && !c_err) begin
      mem[c_idx] <= c_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (latency 2, 0, 15) driven by directed and
// random requests, checked against a word-array reference model.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];
  logic        busy      [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] ref_mem  [3][1024];
  bit          known    [3][1024];
  int          last_acc [3];

  dmem_responder #(.DEPTH(1024), .LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0])
  );
  dmem_responder #(.DEPTH(1024), .LATENCY(0)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1])
  );
  dmem_responder #(.DEPTH(1024), .LATENCY(15)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_we(req_we[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_ready(req_ready[2]),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]), .busy(busy[2])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 0 : 15);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd1024);
  endfunction

  // One full request: wait for ready, accept, check every wait cycle, check the response.
  task automatic do_txn(input int d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit hold, input bit toggle,
                        input bit spacing);
    int lat, n, acc, widx;
    logic exp_err;
    logic [31:0] exp_data;
    bit chk_data;
    lat      = lat_of(d);
    exp_err  = model_err(addr);
    widx     = int'((addr >> 2) % 1024);
    exp_data = 32'd0;
    chk_data = 1'b1;
    if (!we && !exp_err) begin
      exp_data = ref_mem[d][widx];
      chk_data = known[d][widx];
    end
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 50), 32'd1);
    chk("idle_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    chk("idle_busy", 32'(busy[d]), 32'd0);
    acc = cyc;
    if (spacing) chk("accept_spacing", 32'(acc - last_acc[d]), 32'(lat + 2));
    last_acc[d] = acc;
    @(posedge clk);
    #1;
    if (!hold) req_valid[d] = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      if (toggle) begin
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        req_we[d]    = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      chk("wait_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("wait_busy", 32'(busy[d]), 32'd1);
      chk("wait_ready", 32'(req_ready[d]), 32'd0);
    end
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid[d]), 32'd1);
    chk("rsp_busy", 32'(busy[d]), 32'd1);
    chk("rsp_ready", 32'(req_ready[d]), 32'd0);
    chk("rsp_err", 32'(rsp_err[d]), 32'(exp_err));
    if (chk_data) chk("rsp_rdata", rsp_rdata[d], exp_data);
    if (we && !exp_err) begin
      ref_mem[d][widx] = wdata;
      known[d][widx]   = 1'b1;
    end
    $display("txn dut%0d lat=%0d we=%0d addr=%h wdata=%h -> err=%0d rdata=%h (exp err=%0d rdata=%h)",
             d, lat, we, addr, wdata, rsp_err[d], rsp_rdata[d], exp_err, exp_data);
  endtask

  // Store aborted by reset 'delay' negedges after accept; delay = lat+1 lands in the response cycle.
  task automatic rst_abort(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                           input int delay);
    int lat, n;
    lat = lat_of(d);
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d]    = 1'b1;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_accept_timeout", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    repeat (delay) @(negedge clk);
    chk("abort_busy_before", 32'(busy[d]), 32'd1);
    if (delay == lat + 1) begin
      chk("abort_rsp_in_resp", 32'(rsp_valid[d]), 32'd1);
      ref_mem[d][(addr >> 2) % 1024] = wdata;
      known[d][(addr >> 2) % 1024]   = 1'b1;
    end
    rst = 1'b1;
    #1;
    chk("abort_ready_in_rst", 32'(req_ready[d]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy_after", 32'(busy[d]), 32'd0);
    chk("abort_rsp_after", 32'(rsp_valid[d]), 32'd0);
    for (int k = 0; k < lat + 2; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid[d]), 32'd0);
    end
    $display("abort dut%0d addr=%h wdata=%h delay=%0d busy=%0d", d, addr, wdata, delay, busy[d]);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    logic [31:0] idx;
    r   = $urandom_range(0, 9);
    idx = 32'($urandom_range(0, 31));
    case (r)
      6:       return (idx << 2) | 32'($urandom_range(1, 3));
      7:       return $urandom | 32'h0000_1000;
      8:       return 32'h0001_0000 | (idx << 2);
      9:       return 32'h0000_0FFC;
      default: return idx << 2;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = 32'd0;
      req_wdata[d] = 32'd0;
      last_acc[d]  = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) chk("reset_ready_low", 32'(req_ready[d]), 32'd0);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("reset_rsp_err", 32'(rsp_err[d]), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata[d], 32'd0);
      chk("reset_busy", 32'(busy[d]), 32'd0);
      chk("reset_ready_high", 32'(req_ready[d]), 32'd1);
    end

    // Latency 2: store/load, error cases, ignored inputs while busy, reset aborts.
    do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    do_txn(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    do_txn(0, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0, 1'b0);
    do_txn(0, 1'b1, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
    do_txn(0, 1'b1, 32'h1000, 32'h11111111, 1'b0, 1'b0, 1'b0);
    do_txn(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    do_txn(0, 1'b1, 32'h0001_0010, 32'h22222222, 1'b0, 1'b0, 1'b0);
    do_txn(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    do_txn(0, 1'b1, 32'h40, 32'h5A5A0F0F, 1'b0, 1'b1, 1'b0);
    do_txn(0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0);
    do_txn(0, 1'b1, 32'h20, 32'hAAAA5555, 1'b0, 1'b0, 1'b0);
    rst_abort(0, 32'h20, 32'h12345678, 1);
    do_txn(0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
    rst_abort(0, 32'h20, 32'h87654321, 2);
    do_txn(0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
    rst_abort(0, 32'h20, 32'h0BADF00D, 3);
    do_txn(0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);

    // Latency 0: back-to-back loads with req_valid held high.
    do_txn(1, 1'b1, 32'h8, 32'h01020304, 1'b0, 1'b0, 1'b0);
    do_txn(1, 1'b1, 32'hC, 32'h05060708, 1'b0, 1'b0, 1'b0);
    do_txn(1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 1'b0);
    do_txn(1, 1'b0, 32'hC, 32'h0, 1'b1, 1'b0, 1'b1);
    do_txn(1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 1'b1);
    do_txn(1, 1'b0, 32'h3FF1, 32'h0, 1'b0, 1'b0, 1'b0);

    // Latency 15: maximum wait.
    do_txn(2, 1'b1, 32'h4, 32'h77778888, 1'b0, 1'b0, 1'b0);
    do_txn(2, 1'b0, 32'h4, 32'h0, 1'b0, 1'b1, 1'b0);

    // Random mix on every instance.
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < ((d == 2) ? 8 : 30); i++) begin
        do_txn(d, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 1'b0,
               1'($urandom_range(0, 1)), 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
